// File: rtl/esp32_spi_multipad.sv
// Write-only SPI receiver for ESP32 gamepad frames (mode 0, LSB-first).
// Synchronises the SPI pins, validates frame length, and publishes pad state with edge flags.
module esp32_spi_multipad #(
    parameter int unsigned PAD_BUTTONS    = 12,
    parameter int unsigned PAD_COUNT      = 2,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    localparam int unsigned FRAME_BITS    = PAD_COUNT * PAD_BUTTONS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_csn_i,
    input  logic                  spi_clk_i,
    input  logic                  spi_mosi_i,
    output logic [FRAME_BITS-1:0] pad_btn_o,
    output logic [FRAME_BITS-1:0] pad_pressed_o,
    output logic                  frame_valid_o,
    output logic                  frame_error_o,
    output logic                  connected_o
);

    localparam int unsigned BitCntW  = $clog2(FRAME_BITS + 2);
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        StIdle,
        StReceive
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   csn_prev_q, sclk_prev_q;
    logic                   csn_s, sclk_s, mosi_s;
    logic                   csn_fall, csn_rise, sclk_rise;

    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] btn_q, btn_d;
    logic [FRAME_BITS-1:0] pressed_q, pressed_d;
    logic [TimeoutW-1:0]   timeout_q, timeout_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    logic                  conn_q, conn_d;
    logic                  commit;

    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign csn_fall  = csn_prev_q & ~csn_s;
    assign csn_rise  = ~csn_prev_q & csn_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            csn_sync_q  <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            csn_prev_q  <= csn_s;
            sclk_prev_q <= sclk_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        btn_d     = btn_q;
        pressed_d = pressed_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        conn_d    = conn_q;
        commit    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A csn rise here (e.g. reset mid-frame) is deliberately ignored.
                if (csn_fall) begin
                    state_d   = StReceive;
                    bit_cnt_d = '0;
                end
            end
            StReceive: begin
                if (csn_rise) begin
                    state_d = StIdle;
                    if (bit_cnt_q == BitCntW'(FRAME_BITS)) begin
                        commit = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (sclk_rise && !csn_s) begin
                    shift_d = {mosi_s, shift_q[FRAME_BITS-1:1]};
                    if (bit_cnt_q != BitCntW'(FRAME_BITS + 1)) begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A commit in the expiry cycle takes priority over the link-loss clear.
        if (commit) begin
            timeout_d = '0;
            btn_d     = shift_q;
            pressed_d = shift_q & ~btn_q;
            valid_d   = 1'b1;
            conn_d    = 1'b1;
        end else begin
            if (timeout_q != TimeoutW'(TIMEOUT_CYCLES)) begin
                timeout_d = timeout_q + TimeoutW'(1);
            end
            if (timeout_d == TimeoutW'(TIMEOUT_CYCLES)) begin
                conn_d    = 1'b0;
                btn_d     = '0;
                pressed_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            btn_q     <= '0;
            pressed_q <= '0;
            timeout_q <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            conn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            btn_q     <= btn_d;
            pressed_q <= pressed_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            conn_q    <= conn_d;
        end
    end

    assign pad_btn_o     = btn_q;
    assign pad_pressed_o = pressed_q;
    assign frame_valid_o = valid_q;
    assign frame_error_o = error_q;
    assign connected_o   = conn_q;

endmodule

// File: tb/tb_esp32_spi_multipad.sv
// Scoreboard bench for esp32_spi_multipad: frames are modelled per transaction and
// compared by a monitor whenever the DUT pulses frame_valid or frame_error.
module tb_esp32_spi_multipad;

    localparam int unsigned PB = 12;
    localparam int unsigned PC = 2;
    localparam int unsigned FB = PB * PC;
    localparam int unsigned TO = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_csn, spi_clk, spi_mosi;
    logic [FB-1:0] pad_btn, pad_pressed;
    logic          frame_valid, frame_error, connected;

    always #5 clk = ~clk;

    esp32_spi_multipad #(
        .PAD_BUTTONS   (PB),
        .PAD_COUNT     (PC),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi_csn_i    (spi_csn),
        .spi_clk_i    (spi_clk),
        .spi_mosi_i   (spi_mosi),
        .pad_btn_o    (pad_btn),
        .pad_pressed_o(pad_pressed),
        .frame_valid_o(frame_valid),
        .frame_error_o(frame_error),
        .connected_o  (connected)
    );

    typedef struct packed {
        logic          is_valid;
        logic [FB-1:0] btn;
        logic [FB-1:0] pressed;
        logic          conn;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [FB-1:0] model_btn, model_pressed;
    logic          model_conn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: a frame is accepted only if it carries exactly FB bits.
    function automatic exp_t model_frame(input logic [31:0] data, input int nbits);
        exp_t e;
        if (nbits == int'(FB)) begin
            model_pressed = data[FB-1:0] & ~model_btn;
            model_btn     = data[FB-1:0];
            model_conn    = 1'b1;
            e.is_valid    = 1'b1;
        end else begin
            e.is_valid = 1'b0;
        end
        e.btn     = model_btn;
        e.pressed = model_pressed;
        e.conn    = model_conn;
        return e;
    endfunction

    always @(negedge clk) begin
        if (frame_valid || frame_error) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, frame_valid, frame_error}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, frame_valid}, {31'd0, e.is_valid});
                check("pulse_exclusive", {31'd0, frame_valid & frame_error}, 32'd0);
                check("pad_btn", {8'd0, pad_btn}, {8'd0, e.btn});
                check("pad_pressed", {8'd0, pad_pressed}, {8'd0, e.pressed});
                check("connected", {31'd0, connected}, {31'd0, e.conn});
            end
        end
    end

    task automatic clock_bits(input logic [31:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = data[i];
            repeat (2) @(negedge clk);
            spi_clk = 1'b1;
            repeat (2) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits);
        @(negedge clk);
        spi_csn = 1'b0;
        spi_clk = 1'b0;
        repeat (2) @(negedge clk);
        clock_bits(data, nbits);
        repeat (2) @(negedge clk);
        exp_q.push_back(model_frame(data, nbits));
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic model_clear();
        model_btn     = '0;
        model_pressed = '0;
        model_conn    = 1'b0;
    endtask

    initial begin
        int   cnt;
        int   n;
        int   bad_run;
        logic seen;
        logic [31:0] data;

        reset    = 1'b1;
        spi_csn  = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        model_clear();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_btn", {8'd0, pad_btn}, 32'd0);
        check("reset_pressed", {8'd0, pad_pressed}, 32'd0);
        check("reset_pulses", {30'd0, frame_valid, frame_error}, 32'd0);
        check("reset_connected", {31'd0, connected}, 32'd0);

        send_frame(32'h00A005, 24);
        check("t1_btn", {8'd0, pad_btn}, 32'h00A005);
        check("t1_connected", {31'd0, connected}, 32'd1);
        send_frame(32'h00A00C, 24);
        check("t2_pressed", {8'd0, pad_pressed}, 32'h000008);

        send_frame(32'h7FFFFF, 23);
        send_frame(32'h1FFFFFF, 25);
        check("t3_btn_held", {8'd0, pad_btn}, 32'h00A00C);
        check("t3_pressed_held", {8'd0, pad_pressed}, 32'h000008);

        // Link loss: connected must drop exactly TO cycles after the last commit.
        @(negedge clk);
        spi_csn = 1'b0;
        repeat (2) @(negedge clk);
        clock_bits(32'h0F0F0F, 24);
        repeat (2) @(negedge clk);
        exp_q.push_back(model_frame(32'h0F0F0F, 24));
        spi_csn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (frame_valid) seen = 1'b1;
        end
        check("t4_commit_seen", {31'd0, seen}, 32'd1);
        cnt = 0;
        while (connected && cnt < int'(TO) + 20) begin
            @(negedge clk);
            cnt++;
        end
        check("t4_timeout_cycles", cnt, TO);
        check("t4_btn_cleared", {8'd0, pad_btn}, 32'd0);
        check("t4_pressed_cleared", {8'd0, pad_pressed}, 32'd0);
        model_clear();
        send_frame(32'h000001, 24);
        check("t4_reconnect", {31'd0, connected}, 32'd1);
        check("t4_btn", {8'd0, pad_btn}, 32'h000001);

        // Reset in the middle of a frame; csn rises while reset is held.
        @(negedge clk);
        spi_csn = 1'b0;
        repeat (2) @(negedge clk);
        clock_bits(32'h3FF, 10);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        spi_csn = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (4) @(negedge clk);
        check("t5_btn_after_reset", {8'd0, pad_btn}, 32'd0);
        send_frame(32'h123456, 24);
        check("t5_btn", {8'd0, pad_btn}, 32'h123456);

        bad_run = 0;
        for (int f = 0; f < 600; f++) begin
            data = $urandom;
            n = 24;
            if (bad_run < 3 && $urandom_range(0, 4) == 0) n = $urandom_range(0, 30);
            bad_run = (n == 24) ? 0 : bad_run + 1;
            send_frame(data, n);
            check("rand_btn", {8'd0, pad_btn}, {8'd0, model_btn});
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
